// File: rtl/carfield_pkg.sv
// Purpose: shared types and defaults for the Carfield island power sequencer.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package carfield_pkg;

  // Island index order matches the AXI master index order (axi_mst_idx_t).
  typedef enum logic [1:0] {
    SafetyIsland   = 2'd0,
    SecurityIsland = 2'd1,
    FPCluster      = 2'd2,
    IntCluster     = 2'd3
  } carfield_island_e;

  // Default sequencing cycle counts.
  localparam int unsigned PwrSeqClkSettleCycles = 8;
  localparam int unsigned PwrSeqRstHoldCycles   = 16;
  localparam int unsigned PwrSeqIsoTimeout      = 1024;

  typedef enum logic [2:0] {
    IDLE,
    CLK_ON,
    RST_REL,
    ISO_REL,
    ISO_SET,
    RST_SET,
    CLK_OFF
  } pwr_seq_state_e;

  // Largest of three counts; sizes the shared wait counter.
  function automatic int unsigned maxOf3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/carfield_island_rr_pick.sv
// Purpose: round-robin pick of the first pending island at or after a pointer.
// Latency: combinational.
// Backpressure: none; valid is low when nothing is pending.
// Ports: pending (one bit per island), ptr (search start) -> valid, idx (granted island).
module carfield_island_rr_pick #(
  parameter int unsigned NumIslands = 4,
  parameter int unsigned IdxWidth   = (NumIslands > 1) ? $clog2(NumIslands) : 1
) (
  input  logic [NumIslands-1:0] pending,
  input  logic [IdxWidth-1:0]   ptr,
  output logic                  valid,
  output logic [IdxWidth-1:0]   idx
);

  logic [IdxWidth-1:0] candIdx;

  // Walk offsets from farthest to nearest so the closest pending island
  // (smallest offset from ptr, wrapping) is the last one written.
  always_comb begin
    valid   = 1'b0;
    idx     = '0;
    candIdx = '0;
    for (int k = NumIslands - 1; k >= 0; k--) begin
      candIdx = IdxWidth'((int'(ptr) + k) % int'(NumIslands));
      if (pending[candIdx]) begin
        valid = 1'b1;
        idx   = candIdx;
      end
    end
  end

endmodule

// File: rtl/carfield_island_pwr_seq.sv
// Purpose: sequences one island at a time through clock/reset/isolation power-up or power-down.
// Latency: outputs registered; a granted sequence starts the cycle after it is picked in IDLE.
// Backpressure: pending requests wait while busy; isolation handshake waits are bounded by IsoTimeout.
// Ports: clk_i/rst_i (sync, active-high); en_req_i desired state; err_clr_i clears err_o;
//        iso_ack_i isolation ack; clk_en_o/rst_o/iso_o island controls; on_o up; busy_o; err_o sticky timeout.
module carfield_island_pwr_seq
  import carfield_pkg::*;
#(
  parameter int unsigned NumIslands      = 4,
  parameter int unsigned ClkSettleCycles = PwrSeqClkSettleCycles,
  parameter int unsigned RstHoldCycles   = PwrSeqRstHoldCycles,
  parameter int unsigned IsoTimeout      = PwrSeqIsoTimeout
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumIslands-1:0] en_req_i,
  input  logic [NumIslands-1:0] err_clr_i,
  input  logic [NumIslands-1:0] iso_ack_i,
  output logic [NumIslands-1:0] clk_en_o,
  output logic [NumIslands-1:0] rst_o,
  output logic [NumIslands-1:0] iso_o,
  output logic [NumIslands-1:0] on_o,
  output logic                  busy_o,
  output logic [NumIslands-1:0] err_o
);

  localparam int unsigned CntWidth =
    $clog2(maxOf3(ClkSettleCycles, RstHoldCycles, IsoTimeout) + 1);
  localparam int unsigned IdxWidth = (NumIslands > 1) ? $clog2(NumIslands) : 1;

  pwr_seq_state_e        state, stateD;
  logic [IdxWidth-1:0]   grant, grantD;
  logic [IdxWidth-1:0]   rrPtr, rrPtrD;
  logic [CntWidth-1:0]   cnt, cntD;
  logic [NumIslands-1:0] clkEnD, rstD, isoD, onD, errD, errSet;
  logic                  busyD;

  logic [NumIslands-1:0] pending;
  logic                  pickValid;
  logic [IdxWidth-1:0]   pickIdx;

  // Islands in error are parked until software clears the flag.
  assign pending = (en_req_i ^ on_o) & ~err_o;

  carfield_island_rr_pick #(
    .NumIslands(NumIslands),
    .IdxWidth  (IdxWidth)
  ) i_rr_pick (
    .pending(pending),
    .ptr    (rrPtr),
    .valid  (pickValid),
    .idx    (pickIdx)
  );

  // Each wait state is entered with count-1 loaded so it lasts exactly 'count'
  // cycles; the output change of a state is applied on the edge that enters it.
  always_comb begin
    stateD = state;
    grantD = grant;
    rrPtrD = rrPtr;
    cntD   = cnt;
    clkEnD = clk_en_o;
    rstD   = rst_o;
    isoD   = iso_o;
    onD    = on_o;
    errSet = '0;
    unique case (state)
      IDLE: begin
        if (pickValid) begin
          grantD = pickIdx;
          rrPtrD = (pickIdx == IdxWidth'(NumIslands - 1)) ? '0 : pickIdx + IdxWidth'(1);
          if (en_req_i[pickIdx]) begin
            stateD          = CLK_ON;
            clkEnD[pickIdx] = 1'b1;
            cntD            = CntWidth'(ClkSettleCycles - 1);
          end else begin
            stateD        = ISO_SET;
            isoD[pickIdx] = 1'b1;
            onD[pickIdx]  = 1'b0;
            cntD          = CntWidth'(IsoTimeout - 1);
          end
        end
      end
      CLK_ON: begin
        if (cnt == '0) begin
          stateD      = RST_REL;
          rstD[grant] = 1'b0;
          cntD        = CntWidth'(RstHoldCycles - 1);
        end else begin
          cntD = cnt - CntWidth'(1);
        end
      end
      RST_REL: begin
        if (cnt == '0) begin
          stateD      = ISO_REL;
          isoD[grant] = 1'b0;
          cntD        = CntWidth'(IsoTimeout - 1);
        end else begin
          cntD = cnt - CntWidth'(1);
        end
      end
      ISO_REL: begin
        if (!iso_ack_i[grant]) begin
          stateD     = IDLE;
          onD[grant] = 1'b1;
        end else if (cnt == '0) begin
          // Island never left isolation: re-isolate and take it back down.
          stateD        = RST_SET;
          errSet[grant] = 1'b1;
          isoD[grant]   = 1'b1;
          rstD[grant]   = 1'b1;
        end else begin
          cntD = cnt - CntWidth'(1);
        end
      end
      ISO_SET: begin
        if (iso_ack_i[grant] || cnt == '0) begin
          // On timeout the island is forced down with transactions possibly in flight.
          stateD        = RST_SET;
          errSet[grant] = !iso_ack_i[grant];
          rstD[grant]   = 1'b1;
        end else begin
          cntD = cnt - CntWidth'(1);
        end
      end
      RST_SET: begin
        stateD        = CLK_OFF;
        clkEnD[grant] = 1'b0;
      end
      CLK_OFF: begin
        stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
    // A new timeout outranks a simultaneous clear.
    errD  = (err_o & ~err_clr_i) | errSet;
    busyD = (stateD != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      grant    <= '0;
      rrPtr    <= '0;
      cnt      <= '0;
      clk_en_o <= '0;
      rst_o    <= '1;
      iso_o    <= '1;
      on_o     <= '0;
      busy_o   <= 1'b0;
      err_o    <= '0;
    end else begin
      state    <= stateD;
      grant    <= grantD;
      rrPtr    <= rrPtrD;
      cnt      <= cntD;
      clk_en_o <= clkEnD;
      rst_o    <= rstD;
      iso_o    <= isoD;
      on_o     <= onD;
      busy_o   <= busyD;
      err_o    <= errD;
    end
  end

endmodule

// File: tb/tb_carfield_island_pwr_seq.sv
module tb_carfield_island_pwr_seq;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] en_req_i, err_clr_i, iso_ack_i;
  logic [3:0] clk_en_o, rst_o, iso_o, on_o, err_o;
  logic       busy_o;

  always #5 clk_i = ~clk_i;

  carfield_island_pwr_seq dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_req_i (en_req_i),
    .err_clr_i(err_clr_i),
    .iso_ack_i(iso_ack_i),
    .clk_en_o (clk_en_o),
    .rst_o    (rst_o),
    .iso_o    (iso_o),
    .on_o     (on_o),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  typedef struct {
    int isl;
    bit up;
  } seq_t;

  seq_t       expQ[$];
  int         nTests = 0;
  int         nFail  = 0;
  logic       prevBusy = 1'b0;
  logic [3:0] prevClk = '0, prevIso = '1, prevOn = '0;
  logic [3:0] ackAuto  = '1;  // islands whose ack follows iso_o one cycle late
  logic [3:0] ackForce = '0;  // ack value of the other islands

  task automatic applyAck();
    iso_ack_i = (iso_o & ackAuto) | (ackForce & ~ackAuto);
  endtask

  // One clock; samples 1ns after the edge and scores every sequence start
  // against the expected (island, direction) queue.
  task automatic tick();
    seq_t e;
    int   isl;
    bit   up;
    @(posedge clk_i);
    #1;
    if (busy_o && !prevBusy) begin
      isl = -1;
      up  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (clk_en_o[i] && !prevClk[i]) begin
          isl = i; up = 1'b1;
        end else if ((iso_o[i] && !prevIso[i]) || (prevOn[i] && !on_o[i])) begin
          isl = i; up = 1'b0;
        end
      end
      nTests++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("FAIL seq_unexpected: island %0d up=%0d started, none expected", isl, up);
      end else begin
        e = expQ.pop_front();
        if (isl !== e.isl || up !== e.up) begin
          nFail++;
          $display("FAIL seq_order: got island %0d up=%0d, expected island %0d up=%0d",
                   isl, up, e.isl, e.up);
        end
      end
    end
    prevBusy = busy_o;
    prevClk  = clk_en_o;
    prevIso  = iso_o;
    prevOn   = on_o;
    applyAck();
  endtask

  task automatic doReset();
    rst_i     = 1'b1;
    en_req_i  = '0;
    err_clr_i = '0;
    ackAuto   = '1;
    ackForce  = '0;
    expQ.delete();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i    = 1'b1;
    en_req_i = 4'b1111;
    tick();
    tick();
    nTests++;
    if ({clk_en_o, rst_o, iso_o, on_o, busy_o, err_o} !== {4'h0, 4'hF, 4'hF, 4'h0, 1'b0, 4'h0}) begin
      nFail++;
      $display("FAIL reset_values: got clk_en=%b rst=%b iso=%b on=%b busy=%b err=%b",
               clk_en_o, rst_o, iso_o, on_o, busy_o, err_o);
    end
    en_req_i = '0;
    rst_i    = 1'b0;
    repeat (3) tick();
    nTests++;
    if (busy_o !== 1'b0) begin
      nFail++;
      $display("FAIL idle_no_req: busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_power_up();
    int n;
    doReset();
    ackAuto  = 4'b1011;
    ackForce = 4'b0100;
    applyAck();
    en_req_i = 4'b0100;
    expQ.push_back('{2, 1'b1});
    tick();
    nTests++;
    if (clk_en_o !== 4'b0100) begin
      nFail++;
      $display("FAIL pu_clk_en: clk_en=%b expected 0100", clk_en_o);
    end
    for (n = 1; n <= 40; n++) begin tick(); if (!rst_o[2]) break; end
    nTests++;
    if (n != 8) begin
      nFail++;
      $display("FAIL pu_rst_rel: rst fell after %0d cycles, expected 8", n);
    end
    for (n = 1; n <= 40; n++) begin tick(); if (!iso_o[2]) break; end
    nTests++;
    if (n != 16) begin
      nFail++;
      $display("FAIL pu_iso_rel: iso fell after %0d cycles, expected 16", n);
    end
    repeat (3) tick();
    nTests++;
    if (on_o[2] !== 1'b0 || busy_o !== 1'b1) begin
      nFail++;
      $display("FAIL pu_wait_ack: on=%b busy=%b expected on=0 busy=1", on_o[2], busy_o);
    end
    ackForce[2] = 1'b0;
    applyAck();
    tick();
    nTests++;
    if ({on_o, iso_o, rst_o, clk_en_o, busy_o} !== {4'b0100, 4'b1011, 4'b1011, 4'b0100, 1'b0}) begin
      nFail++;
      $display("FAIL pu_done: on=%b iso=%b rst=%b clk_en=%b busy=%b", on_o, iso_o, rst_o, clk_en_o, busy_o);
    end
    nTests++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL pu_seq_missing: %0d sequences not seen", expQ.size());
    end
  endtask

  task automatic test_round_robin();
    int n;
    doReset();
    en_req_i = 4'b1111;
    for (int i = 0; i < 4; i++) expQ.push_back('{i, 1'b1});
    for (n = 1; n <= 300; n++) begin tick(); if (on_o == 4'b1111 && !busy_o) break; end
    nTests++;
    if (n > 300 || expQ.size() != 0) begin
      nFail++;
      $display("FAIL rr_up: on=%b after %0d cycles, %0d sequences missing", on_o, n, expQ.size());
    end
    en_req_i = 4'b0000;
    for (int i = 0; i < 4; i++) expQ.push_back('{i, 1'b0});
    for (n = 1; n <= 300; n++) begin tick(); if (clk_en_o == 4'b0000 && !busy_o) break; end
    nTests++;
    if (n > 300 || expQ.size() != 0 || {on_o, rst_o, iso_o, err_o} !== {4'h0, 4'hF, 4'hF, 4'h0}) begin
      nFail++;
      $display("FAIL rr_down: on=%b rst=%b iso=%b err=%b after %0d cycles, %0d missing",
               on_o, rst_o, iso_o, err_o, n, expQ.size());
    end
  endtask

  task automatic test_up_timeout();
    int n;
    int busySeen;
    doReset();
    ackAuto  = 4'b1101;
    ackForce = 4'b0010;
    applyAck();
    en_req_i = 4'b0010;
    expQ.push_back('{1, 1'b1});
    for (n = 1; n <= 60; n++) begin tick(); if (!iso_o[1]) break; end
    for (n = 1; n <= 1100; n++) begin tick(); if (err_o[1]) break; end
    nTests++;
    if (n != 1024) begin
      nFail++;
      $display("FAIL put_err_time: err after %0d cycles, expected 1024", n);
    end
    nTests++;
    if ({iso_o[1], rst_o[1], on_o[1]} !== 3'b110) begin
      nFail++;
      $display("FAIL put_outputs: iso=%b rst=%b on=%b expected 1 1 0", iso_o[1], rst_o[1], on_o[1]);
    end
    tick();
    tick();
    nTests++;
    if (clk_en_o[1] !== 1'b0 || busy_o !== 1'b0) begin
      nFail++;
      $display("FAIL put_clk_off: clk_en=%b busy=%b expected 0 0", clk_en_o[1], busy_o);
    end
    busySeen = 0;
    repeat (30) begin tick(); if (busy_o) busySeen++; end
    nTests++;
    if (busySeen != 0) begin
      nFail++;
      $display("FAIL put_blocked: busy high %0d cycles while in error, expected 0", busySeen);
    end
    err_clr_i = 4'b0010;
    ackAuto   = 4'b1111;
    expQ.push_back('{1, 1'b1});
    tick();
    err_clr_i = '0;
    nTests++;
    if (err_o !== 4'b0000) begin
      nFail++;
      $display("FAIL put_clear: err=%b expected 0000", err_o);
    end
    for (n = 1; n <= 60; n++) begin tick(); if (on_o[1]) break; end
    nTests++;
    if (n > 60 || expQ.size() != 0) begin
      nFail++;
      $display("FAIL put_retry: on=%b after %0d cycles, %0d missing", on_o, n, expQ.size());
    end
  endtask

  task automatic test_down_forced();
    int n;
    doReset();
    en_req_i = 4'b1000;
    expQ.push_back('{3, 1'b1});
    for (n = 1; n <= 60; n++) begin tick(); if (on_o[3]) break; end
    ackAuto  = 4'b0111;
    ackForce = 4'b0000;
    applyAck();
    en_req_i = 4'b0000;
    expQ.push_back('{3, 1'b0});
    tick();
    nTests++;
    if (on_o[3] !== 1'b0 || iso_o[3] !== 1'b1) begin
      nFail++;
      $display("FAIL pdf_entry: on=%b iso=%b expected 0 1", on_o[3], iso_o[3]);
    end
    for (n = 1; n <= 1100; n++) begin tick(); if (err_o[3]) break; end
    nTests++;
    if (n != 1024 || rst_o[3] !== 1'b1 || clk_en_o[3] !== 1'b1) begin
      nFail++;
      $display("FAIL pdf_err: err after %0d cycles (expected 1024), rst=%b clk_en=%b expected 1 1",
               n, rst_o[3], clk_en_o[3]);
    end
    tick();
    nTests++;
    if (clk_en_o[3] !== 1'b0) begin
      nFail++;
      $display("FAIL pdf_clk_off: clk_en=%b expected 0", clk_en_o[3]);
    end
    tick();
    nTests++;
    if (busy_o !== 1'b0 || expQ.size() != 0) begin
      nFail++;
      $display("FAIL pdf_done: busy=%b expected 0, %0d missing", busy_o, expQ.size());
    end
  endtask

  task automatic test_toggle();
    int n;
    doReset();
    en_req_i = 4'b0001;
    expQ.push_back('{0, 1'b1});
    expQ.push_back('{0, 1'b0});
    for (n = 1; n <= 30; n++) begin tick(); if (!rst_o[0]) break; end
    en_req_i = 4'b0000;
    for (n = 1; n <= 60; n++) begin tick(); if (on_o[0]) break; end
    nTests++;
    if (n > 60 || busy_o !== 1'b0) begin
      nFail++;
      $display("FAIL tog_up: on=%b busy=%b after %0d cycles, expected on=1 busy=0", on_o[0], busy_o, n);
    end
    tick();
    nTests++;
    if (on_o[0] !== 1'b0 || busy_o !== 1'b1 || iso_o[0] !== 1'b1) begin
      nFail++;
      $display("FAIL tog_down_start: on=%b busy=%b iso=%b expected 0 1 1", on_o[0], busy_o, iso_o[0]);
    end
    for (n = 1; n <= 30; n++) begin tick(); if (!busy_o) break; end
    nTests++;
    if (clk_en_o !== 4'b0000 || rst_o !== 4'b1111 || expQ.size() != 0) begin
      nFail++;
      $display("FAIL tog_down_done: clk_en=%b rst=%b, %0d missing", clk_en_o, rst_o, expQ.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    doReset();
    en_req_i = 4'b0110;
    expQ.push_back('{1, 1'b1});
    for (n = 1; n <= 60; n++) begin tick(); if (!iso_o[1]) break; end
    rst_i    = 1'b1;
    en_req_i = 4'b0101;
    tick();
    nTests++;
    if ({clk_en_o, rst_o, iso_o, on_o, busy_o, err_o} !== {4'h0, 4'hF, 4'hF, 4'h0, 1'b0, 4'h0}) begin
      nFail++;
      $display("FAIL rm_values: got clk_en=%b rst=%b iso=%b on=%b busy=%b err=%b",
               clk_en_o, rst_o, iso_o, on_o, busy_o, err_o);
    end
    rst_i = 1'b0;
    // A cleared pointer picks island 0 before island 2.
    expQ.push_back('{0, 1'b1});
    for (n = 1; n <= 5; n++) begin tick(); if (busy_o) break; end
    nTests++;
    if (n > 5 || expQ.size() != 0) begin
      nFail++;
      $display("FAIL rm_pointer: busy=%b after %0d cycles, %0d sequences missing", busy_o, n, expQ.size());
    end
  endtask

  initial begin
    rst_i     = 1'b1;
    en_req_i  = '0;
    err_clr_i = '0;
    iso_ack_i = '1;
    test_reset();
    test_power_up();
    test_round_robin();
    test_up_timeout();
    test_down_forced();
    test_toggle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
